// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of {word, pc} with
// the head pre-split into LC-3b decode fields. Define IRQ_BYPASS_EN for an empty-queue bypass.
module ir_queue #(
  parameter int DEPTH = 4,
  parameter int PCW   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_word,
  input  logic [PCW-1:0]               in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_word,
  output logic [PCW-1:0]               out_pc,
  output logic [3:0]                   opcode,
  output logic [2:0]                   dest,
  output logic [2:0]                   src1,
  output logic [2:0]                   src2,
  output logic [5:0]                   offset6,
  output logic [8:0]                   offset9,
  output logic [10:0]                  offset11,
  output logic [7:0]                   trapvect8,
  output logic [4:0]                   imm5,
  output logic [3:0]                   imm4,
  output logic                         imm5_sel,
  output logic                         ir11,
  output logic                         abit,
  output logic                         dbit,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [15:0]    mem_word [DEPTH];
  logic [PCW-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic           enq, deq, bypass_take;
  logic [15:0]    head_word;
  logic [PCW-1:0] head_pc;

  always_comb begin
    in_ready    = (count != CW'(DEPTH));
    out_valid   = (count != '0);
    head_word   = mem_word[rd_ptr];
    head_pc     = mem_pc[rd_ptr];
    bypass_take = 1'b0;
`ifdef IRQ_BYPASS_EN
    // Empty queue: present the incoming word directly; if decode takes it now, it is never stored.
    if ((count == '0) && in_valid && !flush) begin
      head_word   = in_word;
      head_pc     = in_pc;
      out_valid   = 1'b1;
      bypass_take = out_ready;
    end
`endif
    enq = in_valid && in_ready && !bypass_take;
    deq = out_valid && out_ready && !bypass_take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      mem_word[wr_ptr] <= in_word;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  // Masking keeps never-written storage from leaking X into decode.
  assign out_word  = out_valid ? head_word : '0;
  assign out_pc    = out_valid ? head_pc   : '0;

  assign opcode    = out_word[15:12];
  assign dest      = out_word[11:9];
  assign src1      = out_word[8:6];
  assign src2      = out_word[2:0];
  assign offset6   = out_word[5:0];
  assign offset9   = out_word[8:0];
  assign offset11  = out_word[10:0];
  assign trapvect8 = out_word[7:0];
  assign imm5      = out_word[4:0];
  assign imm4      = out_word[3:0];
  assign imm5_sel  = out_word[5];
  assign ir11      = out_word[11];
  assign abit      = out_word[5];
  assign dbit      = out_word[4];

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: directed steps then random traffic, each cycle compared
// against a queue-based reference model of the FIFO.
module tb_ir_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_word, in_pc, out_word, out_pc;
  logic [3:0]  opcode, imm4;
  logic [2:0]  dest, src1, src2;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [10:0] offset11;
  logic [7:0]  trapvect8;
  logic [4:0]  imm5;
  logic        imm5_sel, ir11, abit, dbit;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  logic [31:0] mq[$];  // {pc, word}, head at index 0

  ir_queue #(.DEPTH(DEPTH), .PCW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_pc(out_pc),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset6(offset6), .offset9(offset9), .offset11(offset11), .trapvect8(trapvect8),
    .imm5(imm5), .imm4(imm4), .imm5_sel(imm5_sel), .ir11(ir11),
    .abit(abit), .dbit(dbit), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fields(input logic [15:0] w);
    return {4'h0, w[15:12], w[11:9], w[8:6], w[2:0], w[5:0], w[8:0], w[10:0],
            w[7:0], w[4:0], w[3:0], w[5], w[11], w[5], w[4]};
  endfunction

  function automatic logic [63:0] dut_fields();
    return {4'h0, opcode, dest, src1, src2, offset6, offset9, offset11,
            trapvect8, imm5, imm4, imm5_sel, ir11, abit, dbit};
  endfunction

  // Entered just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic iv, input logic [15:0] w, input logic [15:0] p,
                       input logic ordy, input logic fl);
    logic [15:0] ew, ep;
    logic ev, er, byp, enq, deq;
    in_valid = iv; in_word = w; in_pc = p; out_ready = ordy; flush = fl;
    #1;
    er  = (mq.size() != DEPTH);
    byp = 1'b0;
`ifdef IRQ_BYPASS_EN
    byp = (mq.size() == 0) && iv && !fl;
`endif
    ev = (mq.size() != 0) || byp;
    if (mq.size() != 0) {ep, ew} = mq[0];
    else if (byp)       {ep, ew} = {p, w};
    else                {ep, ew} = 32'h0;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready",  64'(in_ready),  64'(er));
    chk("count",     64'(count),     64'(mq.size()));
    chk("out_word",  64'(out_word),  64'(ew));
    chk("out_pc",    64'(out_pc),    64'(ep));
    chk("fields",    dut_fields(),   fields(ew));
    enq = iv && er;
    deq = ev && ordy;
    @(posedge clk);
    if (fl) mq.delete();
    else if (!(byp && ordy)) begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back({p, w});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 16'h0, 16'h0, ordy, 1'b0);
  endtask

  initial begin
    logic [3:0] exp_op [4];
    logic [15:0] fill_w [4];
    exp_op = '{4'hF, 4'h0, 4'h6, 4'hD};
    fill_w = '{16'hF025, 16'h0402, 16'h6283, 16'hD0A4};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_word = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_word", 64'(out_word), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD R1,R2,#-3
    cycle(1'b1, 16'h12BD, 16'h3000, 1'b0, 1'b0);
    in_valid = 1'b0; #1;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_count", 64'(count), 64'd1);
    chk("add_opcode", 64'(opcode), 64'h1);
    chk("add_dest", 64'(dest), 64'd1);
    chk("add_src1", 64'(src1), 64'd2);
    chk("add_imm5", 64'(imm5), 64'h1D);
    chk("add_imm5_sel", 64'(imm5_sel), 64'd1);
    chk("add_pc", 64'(out_pc), 64'h3000);
    idle(1'b1);

    // Fill to full, try a fifth word, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_w[i], 16'(16'h3100 + 2*i), 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 16'hBEEF, 16'h3200, 1'b0, 1'b0);
    chk("full_reject_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_opcode", 64'(opcode), 64'(exp_op[i]));
      if (i == 0) chk("drain_trapvect8", 64'(trapvect8), 64'h25);
      idle(1'b1);
    end

    // Full queue with simultaneous in_valid/out_ready: only the dequeue happens.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 16'h4000, 1'b1, 1'b0);
    chk("full_both_count", 64'(count), 64'd3);
    chk("full_both_in_ready", 64'(in_ready), 64'd1);

    // Steady occupancy of 2 across pointer wrap.
    idle(1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    chk("steady_count", 64'(count), 64'd2);

    // Flush with a concurrent enqueue.
    cycle(1'b1, 16'h1111, 16'h5000, 1'b0, 1'b0);
    cycle(1'b1, 16'hAAAA, 16'h5002, 1'b0, 1'b1);
    in_valid = 1'b0; #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_fields", dut_fields(), 64'd0);
    idle(1'b0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'h2345, 16'h6000, 1'b0, 1'b0);
    chk("post_rst_enq", 64'(count), 64'd1);
    idle(1'b1);

`ifdef IRQ_BYPASS_EN
    in_valid = 1'b1; in_word = 16'hC1C0; in_pc = 16'h7000; out_ready = 1'b1; flush = 1'b0;
    #1;
    chk("byp_opcode", 64'(opcode), 64'hC);
    chk("byp_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("byp_count", 64'(count), 64'd0);
    @(negedge clk);
`endif

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
